// File: rtl/result_collector_if.sv
// Result write port: valid/ready stream of narrowed result words with their
// result-memory addresses, from the collector (master) toward result memory.
interface result_collector_if #(
    parameter int OUT_W  = 16,
    parameter int ADDR_W = 8
);
    logic              o_valid;
    logic              o_ready;
    logic [OUT_W-1:0]  o_data;
    logic [ADDR_W-1:0] o_addr;

    modport master (output o_valid, output o_data, output o_addr, input o_ready);
    modport slave  (input o_valid, input o_data, input o_addr, output o_ready);
endinterface

// File: rtl/result_collector.sv
// Captures PE-array results while OutputSign is high, tags them with row-major
// addresses and queues them in a 16-entry FIFO. Macro RESULT_SATURATE_EN selects
// signed saturation to OUT_W instead of plain truncation.
module result_collector #(
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   OutputSign,
    input  logic [1:0]             row_out,
    input  logic [ACC_W-1:0]       pe_data,
    input  logic [ADDR_W-1:0]      base_addr,
    result_collector_if.master     wr,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);
    localparam int DEPTH = 16;

    logic [OUT_W-1:0]  mem_data [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic              mem_last [DEPTH];

    logic [3:0]        wr_ptr, rd_ptr;
    logic [4:0]        count;
    logic [1:0]        col;
    logic              prev_sign;
    logic [ADDR_W-1:0] base_q;

    logic              full, rd_hs, wr_en, frame_start;
    logic [3:0]        idx;
    logic [ADDR_W-1:0] base_cur, entry_addr;

`ifdef RESULT_SATURATE_EN
    function automatic logic [OUT_W-1:0] narrow(input logic [ACC_W-1:0] v);
        logic [ACC_W-OUT_W:0] top;
        top = v[ACC_W-1:OUT_W-1];
        // Value fits only if every bit from the output sign bit upward agrees.
        if (!v[ACC_W-1] && (|top))
            return {1'b0, {(OUT_W-1){1'b1}}};
        else if (v[ACC_W-1] && !(&top))
            return {1'b1, {(OUT_W-1){1'b0}}};
        else
            return v[OUT_W-1:0];
    endfunction
`else
    function automatic logic [OUT_W-1:0] narrow(input logic [ACC_W-1:0] v);
        return v[OUT_W-1:0];
    endfunction
    logic unused_hi;
    assign unused_hi = ^pe_data[ACC_W-1:OUT_W];
`endif

    assign full        = (count == 5'd16);
    assign rd_hs       = wr.o_valid && wr.o_ready;
    assign wr_en       = OutputSign && (!full || rd_hs);
    assign frame_start = OutputSign && !prev_sign;
    assign base_cur    = frame_start ? base_addr : base_q;
    assign idx         = {row_out, col};
    assign entry_addr  = base_cur + {{(ADDR_W-4){1'b0}}, idx};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            prev_sign <= 1'b0;
            col       <= 2'd0;
            base_q    <= '0;
            wr_ptr    <= 4'd0;
            rd_ptr    <= 4'd0;
            count     <= 5'd0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            prev_sign <= OutputSign;
            col       <= OutputSign ? col + 2'd1 : 2'd0;
            if (frame_start)
                base_q <= base_addr;
            if (wr_en)
                wr_ptr <= wr_ptr + 4'd1;
            if (rd_hs)
                rd_ptr <= rd_ptr + 4'd1;
            unique case ({wr_en, rd_hs})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            done <= rd_hs && mem_last[rd_ptr];
            if (OutputSign && full && !rd_hs)
                overflow <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; count gates every use of its contents.
    always_ff @(posedge clk) begin
        if (rstn && wr_en) begin
            mem_data[wr_ptr] <= narrow(pe_data);
            mem_addr[wr_ptr] <= entry_addr;
            mem_last[wr_ptr] <= (idx == 4'd15);
        end
    end

    assign wr.o_valid = (count != 5'd0);
    assign wr.o_data  = wr.o_valid ? mem_data[rd_ptr] : '0;
    assign wr.o_addr  = wr.o_valid ? mem_addr[rd_ptr] : '0;
    assign busy       = rstn && (OutputSign || wr.o_valid);
endmodule

// File: tb/tb_result_collector.sv
// Directed self-checking bench for result_collector (either RESULT_SATURATE_EN build).
module tb_result_collector;
    logic        clk = 1'b0;
    logic        rstn;
    logic        OutputSign;
    logic [1:0]  row_out;
    logic [31:0] pe_data;
    logic [7:0]  base_addr;
    logic        busy, done, overflow;

    result_collector_if #(.OUT_W(16), .ADDR_W(8)) rc_if ();

    result_collector #(.ACC_W(32), .OUT_W(16), .ADDR_W(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .OutputSign (OutputSign),
        .row_out    (row_out),
        .pe_data    (pe_data),
        .base_addr  (base_addr),
        .wr         (rc_if),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] rx_data [$];
    logic [7:0]  rx_addr [$];
    int          done_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_d;
    logic [7:0]  prev_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshakes and stall stability observed mid-cycle, where inputs are settled.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && rc_if.o_valid) begin
                check("stall_data", 32'(rc_if.o_data), 32'(prev_d));
                check("stall_addr", 32'(rc_if.o_addr), 32'(prev_a));
            end
            if (rc_if.o_valid && rc_if.o_ready) begin
                rx_data.push_back(rc_if.o_data);
                rx_addr.push_back(rc_if.o_addr);
            end
            if (done) done_cnt++;
            prev_stall = rc_if.o_valid && !rc_if.o_ready;
            prev_d     = rc_if.o_data;
            prev_a     = rc_if.o_addr;
        end
    end

    task automatic clear_rx();
        rx_data.delete();
        rx_addr.delete();
        done_cnt = 0;
    endtask

    task automatic drive_frame(input logic [7:0] base, input logic [31:0] d0);
        for (int k = 0; k < 16; k++) begin
            OutputSign = 1'b1;
            row_out    = 2'(k >> 2);
            pe_data    = d0 + 32'(k);
            base_addr  = base;
            tick();
        end
        OutputSign = 1'b0;
        pe_data    = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || rc_if.o_valid) && n < 60) begin
            tick();
            n++;
        end
        check("idle_reached", 32'(busy), 32'd0);
        tick();
    endtask

    task automatic check_drain(input logic [7:0] base, input logic [31:0] d0, input int n);
        logic [7:0]  ea;
        logic [31:0] ed;
        check("rx_len", rx_data.size(), n);
        for (int i = 0; i < n && i < rx_data.size(); i++) begin
            ea = base + 8'(i);
            ed = d0 + 32'(i);
            check("rx_addr", 32'(rx_addr[i]), 32'(ea));
            check("rx_data", 32'(rx_data[i]), 32'(ed[15:0]));
        end
    endtask

    logic [15:0] exp_n [3];
    int          n_drain;

    initial begin
        // Reset with random inputs
        rstn        = 1'b0;
        OutputSign  = 1'($urandom);
        row_out     = 2'($urandom);
        pe_data     = $urandom;
        base_addr   = 8'($urandom);
        rc_if.o_ready = 1'($urandom);
        tick();
        tick();
        check("rst_valid", 32'(rc_if.o_valid), 32'd0);
        check("rst_data",  32'(rc_if.o_data),  32'd0);
        check("rst_addr",  32'(rc_if.o_addr),  32'd0);
        check("rst_busy",  32'(busy),          32'd0);
        check("rst_done",  32'(done),          32'd0);
        check("rst_ovf",   32'(overflow),      32'd0);
        rstn = 1'b1;
        OutputSign = 1'b0;
        rc_if.o_ready = 1'b0;
        tick();
        check("post_rst_valid", 32'(rc_if.o_valid), 32'd0);

        // Full frame, no backpressure; first entry visible one cycle after write
        clear_rx();
        rc_if.o_ready = 1'b1;
        OutputSign = 1'b1;
        row_out    = 2'd0;
        pe_data    = 32'd0;
        base_addr  = 8'h40;
        tick();
        check("lat_valid", 32'(rc_if.o_valid), 32'd1);
        check("lat_addr",  32'(rc_if.o_addr),  32'h40);
        check("lat_data",  32'(rc_if.o_data),  32'd0);
        check("lat_busy",  32'(busy),          32'd1);
        for (int k = 1; k < 16; k++) begin
            row_out   = 2'(k >> 2);
            pe_data   = 32'(k);
            base_addr = 8'h99;   // only the frame-start value may be used
            tick();
        end
        OutputSign = 1'b0;
        wait_idle();
        check_drain(8'h40, 32'd0, 16);
        check("frame_done", done_cnt, 1);
        check("frame_ovf", 32'(overflow), 32'd0);

        // Backpressure for a whole frame, then back-to-back drain
        clear_rx();
        rc_if.o_ready = 1'b0;
        drive_frame(8'h20, 32'd100);
        check("bp_count", 32'(dut.count), 32'd16);
        check("bp_ovf", 32'(overflow), 32'd0);
        check("bp_valid", 32'(rc_if.o_valid), 32'd1);
        rc_if.o_ready = 1'b1;
        n_drain = 0;
        while (rc_if.o_valid && n_drain < 40) begin
            tick();
            n_drain++;
        end
        check("bp_drain_cycles", n_drain, 16);
        tick();
        check_drain(8'h20, 32'd100, 16);
        check("bp_done", done_cnt, 1);

        // Overflow across two back-to-back frames
        clear_rx();
        rc_if.o_ready = 1'b0;
        for (int k = 0; k < 32; k++) begin
            OutputSign = 1'b1;
            row_out    = 2'((k % 16) >> 2);
            pe_data    = (k < 16) ? 32'(k) : 32'(50 + k);
            base_addr  = (k < 16) ? 8'h40 : 8'h80;
            tick();
            check("ovf_flag", 32'(overflow), (k >= 16) ? 32'd1 : 32'd0);
        end
        OutputSign = 1'b0;
        rc_if.o_ready = 1'b1;
        wait_idle();
        check_drain(8'h40, 32'd0, 16);
        check("ovf_done", done_cnt, 1);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Narrowing
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        check("ovf_cleared", 32'(overflow), 32'd0);
        clear_rx();
`ifdef RESULT_SATURATE_EN
        exp_n[0] = 16'h7FFF; exp_n[1] = 16'h8000; exp_n[2] = 16'h1234;
`else
        exp_n[0] = 16'h0000; exp_n[1] = 16'h0000; exp_n[2] = 16'h1234;
`endif
        rc_if.o_ready = 1'b1;
        base_addr = 8'h00;
        row_out   = 2'd0;
        OutputSign = 1'b1;
        pe_data = 32'h0001_0000; tick();
        pe_data = 32'hFFFF_0000; tick();
        pe_data = 32'h0000_1234; tick();
        OutputSign = 1'b0;
        wait_idle();
        check("nar_len", rx_data.size(), 3);
        for (int i = 0; i < 3 && i < rx_data.size(); i++) begin
            check("nar_data", 32'(rx_data[i]), 32'(exp_n[i]));
            check("nar_addr", 32'(rx_addr[i]), 32'(i));
        end
        check("nar_done", done_cnt, 0);

        // Reset mid-drain
        clear_rx();
        rc_if.o_ready = 1'b0;
        drive_frame(8'h40, 32'd0);
        rc_if.o_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rstn = 1'b0;
        tick();
        check("mid_valid", 32'(rc_if.o_valid), 32'd0);
        check("mid_data",  32'(rc_if.o_data),  32'd0);
        check("mid_addr",  32'(rc_if.o_addr),  32'd0);
        check("mid_busy",  32'(busy),          32'd0);
        check("mid_done",  32'(done),          32'd0);
        check("mid_rx",    rx_data.size(),     5);
        rstn = 1'b1;
        tick();
        check("mid_empty", 32'(rc_if.o_valid), 32'd0);
        clear_rx();
        drive_frame(8'h10, 32'd200);
        wait_idle();
        check_drain(8'h10, 32'd200, 16);
        check("mid_frame_done", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
